multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
Parametrised multi-channel switch debouncer. Successor to the single-channel debouncer: N independent channels, each with a configurable synchroniser depth and stability window. Each channel provides a debounced level, a rising-edge pulse and a falling-edge pulse, plus a selectable-edge tick. Sits between raw board switch/button inputs and control logic that consumes single-cycle event ticks.

Parameters:
N_CH, 4, number of independent channels (>=1)
DB_CYCLES, 1000, consecutive stable synchronised cycles required to accept a level change (>=2)
SYNC_STAGES, 2, flops in each input synchroniser chain (>=2)
TICK_EDGE, 0, edge(s) reported on db_tick_o: 0 rising, 1 falling, 2 both
CNT_W, $clog2(DB_CYCLES), derived counter width; not overridden

Ports:
clk_i  input  1  single system clock, all logic on rising edge
rst_i  input  1  synchronous, active-high reset
sw_i  input  N_CH  raw asynchronous switch inputs, one bit per channel
db_level_o  output  N_CH  debounced level per channel
db_rise_o  output  N_CH  1-cycle pulse on accepted 0->1 transition
db_fall_o  output  N_CH  1-cycle pulse on accepted 1->0 transition
db_tick_o  output  N_CH  db_rise_o, db_fall_o or their OR, per TICK_EDGE
any_tick_o  output  1  OR-reduction of db_tick_o

Behaviour:
- Reset: rst_i sampled high at a clk_i edge clears all synchroniser flops, counters and FSMs (state ZERO). All outputs read 0 in the next cycle. Reset dominates every other event.
- Synchroniser: sw_i[c] passes through SYNC_STAGES flops; the last stage is s[c]. Only s[c] feeds the FSM.
- Per-channel FSM with states ZERO, WAIT1, ONE, WAIT0 and a CNT_W-bit counter:
  - ZERO: s=1 -> WAIT1, cnt=0; else stay.
  - WAIT1: s=0 -> ZERO, no pulse (bounce rejected). Else if cnt==DB_CYCLES-1 -> ONE, and db_rise_o is registered high. Else cnt++.
  - ONE: s=0 -> WAIT0, cnt=0; else stay.
  - WAIT0: s=1 -> ONE, no pulse. Else if cnt==DB_CYCLES-1 -> ZERO, and db_fall_o is registered high. Else cnt++.
- db_level_o = 1 in ONE and WAIT0, and 0 in ZERO and WAIT1. It is a registered output with no combinational path from sw_i.
- Latency: sw_i is first sampled 1 at edge k and then held stable. db_level_o and db_rise_o go high after edge k+SYNC_STAGES+DB_CYCLES. Falling edges are symmetric.
- Pulses are exactly 1 cycle. The rise pulse coincides with the first cycle of db_level_o=1; the fall pulse coincides with the first cycle of db_level_o=0. The rise and fall pulses of one channel are never high together.
- Any s glitch during WAIT1/WAIT0 aborts the wait. The counter restarts from 0 on the next qualifying entry; there is no partial credit.
- The counter never wraps: it stops at DB_CYCLES-1 by construction.
- Channels are fully independent. Simultaneous events on multiple channels each produce their own pulse in the same cycle. any_tick_o is the combinational OR of the registered db_tick_o.
- Reset mid-WAIT produces no pulse. If sw_i is high at reset release, the channel runs the normal ZERO->WAIT1 path and emits a rise tick after the full latency.
- TICK_EDGE values other than 0, 1 or 2 are illegal and must trigger an elaboration-time $error.

Test Plan:
Config for all scenarios: N_CH=4, DB_CYCLES=16, SYNC_STAGES=2, TICK_EDGE=2.
1. Reset: rst_i high 2 cycles with sw_i=4'hF -> all outputs 0 during reset. After release, each channel rises with one db_rise_o pulse 18 edges after the first sample, and any_tick_o=1 for exactly that cycle.
2. Clean press/release ch0: sw_i[0]=1 for 40 cycles, then 0 for 40 -> db_rise_o[0] 1-cycle pulse at +18 edges and db_level_o[0]=1. Then db_fall_o[0] pulse 18 edges after release, with db_tick_o[0] mirroring both pulses.
3. Bounce ch2: 100 iterations of random high/low durations of 1..15 cycles, then hold 1 for 30 -> zero pulses during bouncing and db_level_o[2]=0. Exactly one rise pulse 18 edges after the final hold starts.
4. Glitch ch1: hold 1, drop sw_i[1] for 1 cycle at cycle 12, then hold 1 -> no pulse at the original +18 edges. Rise occurs 18 edges after the re-assertion.
5. Concurrency: ch1 and ch3 asserted on the same edge, ch2 5 cycles later -> db_rise_o[1] and db_rise_o[3] pulse in the same cycle, db_rise_o[2] 5 cycles later. any_tick_o shows two separate 1-cycle pulses.
6. Reset mid-wait: ch0 held high, rst_i asserted 1 cycle when cnt=10 -> no db_rise_o, db_level_o[0] stays 0. The full 18-edge latency restarts from the first post-reset sample.

Source files
------------

// File: rtl/multi_debounce_if.sv
// Switch inputs and debounced event outputs of the multi-channel debouncer.
// The design side is the slave; the stimulus/consumer side is the master.
interface multi_debounce_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] sw_i;
    logic [N_CH-1:0] db_level_o;
    logic [N_CH-1:0] db_rise_o;
    logic [N_CH-1:0] db_fall_o;
    logic [N_CH-1:0] db_tick_o;
    logic            any_tick_o;

    modport master (
        output sw_i,
        input  db_level_o, db_rise_o, db_fall_o, db_tick_o, any_tick_o
    );

    modport slave (
        input  sw_i,
        output db_level_o, db_rise_o, db_fall_o, db_tick_o, any_tick_o
    );
endinterface

// File: rtl/multi_debounce.sv
// N-channel switch debouncer: per-channel synchroniser plus a stability-window
// FSM producing a debounced level, rise/fall pulses and a selectable-edge tick.
module multi_debounce #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DB_CYCLES   = 1000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TICK_EDGE   = 0,
    localparam int unsigned CNT_W      = $clog2(DB_CYCLES)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    multi_debounce_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam bit RISE_EN = (TICK_EDGE != 1);
    localparam bit FALL_EN = (TICK_EDGE != 0);

    generate
        if (TICK_EDGE > 2) begin : g_bad_tick_edge
            $error("multi_debounce: TICK_EDGE must be 0, 1 or 2");
        end
        if (DB_CYCLES < 2) begin : g_bad_db_cycles
            $error("multi_debounce: DB_CYCLES must be at least 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("multi_debounce: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    logic [SYNC_STAGES-1:0] sync_q  [N_CH];
    state_t                 state_q [N_CH];
    logic [CNT_W-1:0]       cnt_q   [N_CH];

    logic [N_CH-1:0] s;
    logic [N_CH-1:0] rise_c;
    logic [N_CH-1:0] fall_c;
    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] fall_q;
    logic [N_CH-1:0] tick_q;

    // Synchronised sample and end-of-window detection per channel
    always_comb begin
        s      = '0;
        rise_c = '0;
        fall_c = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            s[c]      = sync_q[c][SYNC_STAGES-1];
            rise_c[c] = (state_q[c] == WAIT1) && s[c]  && (cnt_q[c] == CNT_MAX);
            fall_c[c] = (state_q[c] == WAIT0) && !s[c] && (cnt_q[c] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                sync_q[c]  <= '0;
                state_q[c] <= ZERO;
                cnt_q[c]   <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            tick_q  <= '0;
        end else begin
            rise_q <= rise_c;
            fall_q <= fall_c;
            tick_q <= ({N_CH{RISE_EN}} & rise_c) | ({N_CH{FALL_EN}} & fall_c);
            for (int c = 0; c < int'(N_CH); c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], bus.sw_i[c]};
                // A glitch during a wait drops back without credit; the counter
                // is reloaded on the next entry so it can never wrap.
                case (state_q[c])
                    ZERO: begin
                        if (s[c]) begin
                            state_q[c] <= WAIT1;
                            cnt_q[c]   <= '0;
                        end
                    end
                    WAIT1: begin
                        if (!s[c]) begin
                            state_q[c] <= ZERO;
                        end else if (cnt_q[c] == CNT_MAX) begin
                            state_q[c] <= ONE;
                            level_q[c] <= 1'b1;
                        end else begin
                            cnt_q[c] <= cnt_q[c] + 1'b1;
                        end
                    end
                    ONE: begin
                        if (!s[c]) begin
                            state_q[c] <= WAIT0;
                            cnt_q[c]   <= '0;
                        end
                    end
                    WAIT0: begin
                        if (s[c]) begin
                            state_q[c] <= ONE;
                        end else if (cnt_q[c] == CNT_MAX) begin
                            state_q[c] <= ZERO;
                            level_q[c] <= 1'b0;
                        end else begin
                            cnt_q[c] <= cnt_q[c] + 1'b1;
                        end
                    end
                    default: state_q[c] <= ZERO;
                endcase
            end
        end
    end

    assign bus.db_level_o = level_q;
    assign bus.db_rise_o  = rise_q;
    assign bus.db_fall_o  = fall_q;
    assign bus.db_tick_o  = tick_q;
    assign bus.any_tick_o = |tick_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce (4 channels, 16-cycle window, 2 sync stages,
// ticks on both edges): vector table plus hand sequences for bounce/glitch/reset.
module tb_multi_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multi_debounce_if #(.N_CH(4)) bus ();

    multi_debounce #(
        .N_CH(4),
        .DB_CYCLES(16),
        .SYNC_STAGES(2),
        .TICK_EDGE(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        int         hold;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic r, logic [3:0] sw, int hold,
                                logic [3:0] lvl, logic [3:0] ri,
                                logic [3:0] fa, logic an);
        vec_t v;
        v.rst = r; v.sw = sw; v.hold = hold;
        v.level = lvl; v.rise = ri; v.fall = fa; v.any = an;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lvl,
                           input logic [3:0] ri, input logic [3:0] fa,
                           input logic an);
        chk({tag, ".level"}, bus.db_level_o, lvl);
        chk({tag, ".rise"},  bus.db_rise_o,  ri);
        chk({tag, ".fall"},  bus.db_fall_o,  fa);
        chk({tag, ".tick"},  bus.db_tick_o,  ri | fa);
        chk({tag, ".any"},   {3'b000, bus.any_tick_o}, {3'b000, an});
    endtask

    // Step n cycles, requiring channel ch to stay at lvl with no pulses
    task automatic quiet(input string tag, input int n, input int ch, input logic lvl);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, ".no_rise"}, {3'b000, bus.db_rise_o[ch]}, 4'h0);
            chk({tag, ".no_fall"}, {3'b000, bus.db_fall_o[ch]}, 4'h0);
            chk({tag, ".level"},   {3'b000, bus.db_level_o[ch]}, {3'b000, lvl});
        end
    endtask

    task automatic expect_rise(input string tag, input int ch);
        step();
        chk({tag, ".rise"},  {3'b000, bus.db_rise_o[ch]},  4'h1);
        chk({tag, ".tick"},  {3'b000, bus.db_tick_o[ch]},  4'h1);
        chk({tag, ".level"}, {3'b000, bus.db_level_o[ch]}, 4'h1);
        step();
        chk({tag, ".rise_end"}, {3'b000, bus.db_rise_o[ch]}, 4'h0);
        chk({tag, ".level_hold"}, {3'b000, bus.db_level_o[ch]}, 4'h1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sw_i = 4'h0;
        step();
        step();
        chk_all("reset", 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bus.sw_i = 4'hF;

        // Reset with all switches high, then all channels rise together
        vecs.push_back(mk(1, 4'hF, 2,  4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF, 17, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF, 1,  4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF, 1,  4'hF, 4'hF, 4'h0, 1));
        vecs.push_back(mk(0, 4'hF, 1,  4'hF, 4'h0, 4'h0, 0));
        // Clean press/release on ch0
        vecs.push_back(mk(1, 4'h0, 2,  4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h1, 18, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h1, 1,  4'h1, 4'h1, 4'h0, 1));
        vecs.push_back(mk(0, 4'h1, 1,  4'h1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h1, 20, 4'h1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0, 18, 4'h1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'h0, 1,  4'h0, 4'h0, 4'h1, 1));
        vecs.push_back(mk(0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 0));
        // ch1+ch3 together, ch2 five cycles later
        vecs.push_back(mk(0, 4'hA, 5,  4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'hE, 13, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'hE, 1,  4'hA, 4'hA, 4'h0, 1));
        vecs.push_back(mk(0, 4'hE, 4,  4'hA, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'hE, 1,  4'hE, 4'h4, 4'h0, 1));
        vecs.push_back(mk(0, 4'hE, 1,  4'hE, 4'h0, 4'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            bus.sw_i = vecs[i].sw;
            for (int k = 0; k < vecs[i].hold; k++) step();
            chk_all($sformatf("v%0d", i), vecs[i].level, vecs[i].rise,
                    vecs[i].fall, vecs[i].any);
        end

        // Bounce on ch2 never exceeds the window, then a clean hold
        do_reset();
        for (int it = 0; it < 100; it++) begin
            bus.sw_i[2] = 1'b1;
            quiet("bounce_hi", int'($urandom_range(15, 1)), 2, 1'b0);
            bus.sw_i[2] = 1'b0;
            quiet("bounce_lo", int'($urandom_range(15, 1)), 2, 1'b0);
        end
        bus.sw_i[2] = 1'b1;
        quiet("bounce_hold", 18, 2, 1'b0);
        expect_rise("bounce_rise", 2);

        // One-cycle glitch on ch1 restarts the window
        do_reset();
        bus.sw_i[1] = 1'b1;
        quiet("glitch_pre", 12, 1, 1'b0);
        bus.sw_i[1] = 1'b0;
        quiet("glitch_low", 1, 1, 1'b0);
        bus.sw_i[1] = 1'b1;
        quiet("glitch_post", 18, 1, 1'b0);
        expect_rise("glitch_rise", 1);

        // Reset mid-wait on ch0 produces no pulse and restarts the latency
        do_reset();
        bus.sw_i[0] = 1'b1;
        quiet("midrst_pre", 12, 0, 1'b0);
        rst = 1'b1;
        step();
        chk_all("midrst_in", 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        quiet("midrst_post", 18, 0, 1'b0);
        expect_rise("midrst_rise", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
